// File: rtl/aeolus_display_driver.sv
// Display stage behind the CPU output register: captures a 4-deep result history and
// scans it onto a 4-digit active-low multiplexed 7-segment display, newest on digit 0.
module aeolus_display_driver #(
  parameter int REFRESH_COUNT = 100000,
  parameter int BLANK_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] valueIn,
  input  logic       loadStrobe,
  input  logic       freeze,
  output logic [3:0] anodes,
  output logic [6:0] segments,
  output logic       dp,
  output logic [7:0] captureCount
);

  localparam int CW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_COUNT - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [3:0]    history [4];
  logic [3:0]    valid;
  logic          strobe_prev;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;

  logic          capture;
  logic          show;
  logic [3:0]    sel_value;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // An edge seen while frozen still updates strobe_prev, so it is consumed, not deferred.
  always_comb begin
    capture   = loadStrobe & ~strobe_prev & ~freeze;
    sel_value = history[digit_idx];
    show      = valid[digit_idx] & (refresh_cnt >= CNT_BLANK);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      history[0]   <= 4'h0;
      history[1]   <= 4'h0;
      history[2]   <= 4'h0;
      history[3]   <= 4'h0;
      valid        <= 4'b0000;
      strobe_prev  <= 1'b0;
      refresh_cnt  <= '0;
      digit_idx    <= 2'd0;
      captureCount <= 8'd0;
      anodes       <= 4'b1111;
      segments     <= 7'h7F;
      dp           <= 1'b1;
    end else begin
      strobe_prev <= loadStrobe;

      if (refresh_cnt == CNT_LAST) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + CW'(1);
      end

      if (capture) begin
        history[3] <= history[2];
        history[2] <= history[1];
        history[1] <= history[0];
        history[0] <= valueIn;
        valid      <= {valid[2:0], 1'b1};
        if (captureCount != 8'hFF) captureCount <= captureCount + 8'd1;
      end

      // Outputs come from pre-edge state; a capture shows up one cycle later.
      anodes   <= show ? ~(4'b0001 << digit_idx) : 4'b1111;
      segments <= show ? hex7(sel_value) : 7'h7F;
      dp       <= ~(show & freeze & (digit_idx == 2'd0));
    end
  end

endmodule

// File: tb/tb_aeolus_display_driver.sv
// Scoreboard bench for aeolus_display_driver: a scan tracker pushes the expected outputs
// each checked cycle from hand-computed digit codes; a negedge monitor pops and compares.
module tb_aeolus_display_driver;

  localparam int RC = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] valueIn = 4'h0;
  logic       loadStrobe = 1'b0;
  logic       freeze = 1'b0;
  logic [3:0] anodes;
  logic [6:0] segments;
  logic       dp;
  logic [7:0] captureCount;

  aeolus_display_driver #(.REFRESH_COUNT(RC), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .valueIn(valueIn), .loadStrobe(loadStrobe),
    .freeze(freeze), .anodes(anodes), .segments(segments), .dp(dp),
    .captureCount(captureCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // hand-computed expected display content
  logic [3:0] exp_valid = 4'b0000;
  logic [6:0] exp_seg [4] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
  logic [7:0] exp_count = 8'd0;
  logic       chk_en = 1'b1;

  int ph = 0;
  int dg = 0;

  always @(posedge clk) begin
    exp_t e;
    logic shw;
    if (!reset) begin
      e.an = 4'b1111; e.seg = 7'h7F; e.dp = 1'b1; e.cnt = 8'd0;
      if (chk_en) sb.push_back(e);
      ph = 0;
      dg = 0;
    end else begin
      shw   = exp_valid[dg] && (ph >= BC);
      e.an  = 4'b1111;
      if (shw) e.an[dg] = 1'b0;
      e.seg = shw ? exp_seg[dg] : 7'h7F;
      e.dp  = !(shw && freeze && dg == 0);
      e.cnt = exp_count;
      if (chk_en) sb.push_back(e);
      if (ph == RC - 1) begin
        ph = 0;
        dg = (dg + 1) % 4;
      end else begin
        ph = ph + 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (anodes !== e.an || segments !== e.seg || dp !== e.dp || captureCount !== e.cnt) begin
        fails++;
        $display("FAIL scan t=%0t anodes got %b exp %b, segments got %h exp %h, dp got %b exp %b, count got %0d exp %0d",
                 $time, anodes, e.an, segments, e.seg, dp, e.dp, captureCount, e.cnt);
      end
    end
  end

  task automatic set_exp(input logic [3:0] v, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3, input logic [7:0] c);
    exp_valid  = v;
    exp_seg[0] = s0;
    exp_seg[1] = s1;
    exp_seg[2] = s2;
    exp_seg[3] = s3;
    exp_count  = c;
  endtask

  task automatic pulse(input logic [3:0] v);
    @(posedge clk); #1;
    valueIn = v;
    loadStrobe = 1'b1;
    @(posedge clk); #1;
    loadStrobe = 1'b0;
  endtask

  task automatic check_frames(input int n);
    chk_en = 1'b1;
    repeat (n) @(posedge clk);
    #1 chk_en = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    set_exp(4'b0000, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 8'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;

    // reset held 3 cycles, then blank for 100 cycles
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (100) @(posedge clk);
    #1 chk_en = 1'b0;

    // single capture of A, only digit 0 lit
    pulse(4'hA);
    set_exp(4'b0001, 7'h08, 7'h7F, 7'h7F, 7'h7F, 8'd1);
    check_frames(40);

    // shift and overflow from a fresh reset
    do_reset();
    pulse(4'h1);
    pulse(4'h2);
    pulse(4'h3);
    pulse(4'h4);
    set_exp(4'b1111, 7'h19, 7'h30, 7'h24, 7'h79, 8'd4);
    check_frames(40);
    pulse(4'h5);
    set_exp(4'b1111, 7'h12, 7'h19, 7'h30, 7'h24, 8'd5);
    check_frames(40);

    // strobe held for 20 cycles gives one capture
    @(posedge clk); #1;
    valueIn = 4'h6;
    loadStrobe = 1'b1;
    repeat (20) @(posedge clk);
    #1 loadStrobe = 1'b0;
    set_exp(4'b1111, 7'h02, 7'h12, 7'h19, 7'h30, 8'd6);
    check_frames(40);

    // frozen: pulses ignored, dp lit on digit 0
    @(posedge clk); #1 freeze = 1'b1;
    pulse(4'h7);
    pulse(4'h7);
    pulse(4'h7);
    check_frames(40);
    @(posedge clk); #1 loadStrobe = 1'b1;
    repeat (3) @(posedge clk);
    #1 freeze = 1'b0;
    repeat (5) @(posedge clk);
    #1 loadStrobe = 1'b0;
    check_frames(34);
    pulse(4'h8);
    set_exp(4'b1111, 7'h00, 7'h02, 7'h12, 7'h19, 8'd7);
    check_frames(40);

    // saturation
    for (int i = 0; i < 300; i++) pulse(4'h9);
    set_exp(4'b1111, 7'h10, 7'h10, 7'h10, 7'h10, 8'd255);
    check_frames(40);

    // reset in the shown part of the digit-2 window
    chk_en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dg == 2 && ph == 4) begin
        hit = 1'b1;
        break;
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL reset_window_wait got no digit-2 window exp one within 40 cycles");
    end
    reset = 1'b0;
    set_exp(4'b0000, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 8'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk_en = 1'b0;

    // remaining hex codes
    pulse(4'hB);
    pulse(4'hC);
    pulse(4'hD);
    pulse(4'hE);
    set_exp(4'b1111, 7'h06, 7'h21, 7'h46, 7'h03, 8'd4);
    check_frames(40);
    pulse(4'hF);
    pulse(4'h0);
    set_exp(4'b1111, 7'h40, 7'h0E, 7'h06, 7'h21, 8'd6);
    check_frames(40);

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d entries left exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
